signed_divmod_seq: RTL and testbench

- Multi-cycle sequencer for a shared divide/modulo datapath.
- Accepts one operand pair per transaction over a valid/ready handshake and runs W restoring-division iterations.
- Returns quotient and remainder with language-exact semantics:
  - quotient truncates toward zero;
  - remainder takes the sign of the dividend;
  - results are sign- or zero-extended to OUT_W.
- Sits between the arithmetic issue logic and any consumer of `%` and `/` results wider than the operands.

---
 rtl/signed_divmod_pkg.sv | 30 +++
 rtl/signed_divmod_seq_step.sv | 23 ++
 rtl/signed_divmod_seq.sv | 209 ++++++++++++++++++++
 tb/tb_signed_divmod_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_divmod_pkg.sv
// Shared types and helpers for the signed/unsigned sequential divider.
// Holds the FSM state type, the all-ones quotient pattern used for a zero
// divisor, and the sign/zero extension helper used when results leave the block.
package signed_divmod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } divmod_state_e;

    // Widest operand the extension helper handles
    localparam int MAX_W = 64;

    // Quotient pattern reported for a zero divisor (sliced to W by the user)
    localparam logic [MAX_W-1:0] ALL_ONES = '1;

    // Extend the low w bits of value to MAX_W bits, sign- or zero-filling above
    function automatic logic [MAX_W-1:0] ext_to_out(input logic [MAX_W-1:0] value,
                                                    input int w,
                                                    input logic is_signed);
        logic [MAX_W-1:0] r;
        r[0] = value[0];
        for (int i = 1; i < MAX_W; i++) begin
            r[i] = (i < w) ? value[i] : (is_signed & r[i-1]);
        end
        return r;
    endfunction

endpackage

// File: rtl/signed_divmod_seq_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor magnitude and keep the
// difference when it does not go negative.
module divmod_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] rem_in,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor_mag,
    output logic [W-1:0] rem_out,
    output logic         quot_bit
);

    logic [W:0] shifted;

    // Shift, compare and conditionally subtract in a single combinational step
    always_comb begin
        shifted  = {rem_in, dividend_bit};
        quot_bit = (shifted >= {1'b0, divisor_mag});
        rem_out  = W'(quot_bit ? (shifted - {1'b0, divisor_mag}) : shifted);
    end

endmodule

// File: rtl/signed_divmod_seq.sv
// Multi-cycle divide/modulo sequencer with truncating quotient and a
// remainder that follows the dividend's sign. Results are extended to OUT_W.
// Optional build macro: SIGNED_DIVMOD_FASTPATH_EN skips the iteration phase
// when either operand is zero.
module signed_divmod_seq
    import signed_divmod_pkg::*;
#(
    parameter int W     = 8,
    parameter int OUT_W = 12,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_dividend,
    input  logic [W-1:0]     in_divisor,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_quot,
    output logic [OUT_W-1:0] out_rem,
    output logic             out_div_zero
);

    divmod_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     work_q, work_d;
    logic [W-1:0]     dvs_q, dvs_d;
    logic [W-1:0]     dividend_q, dividend_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             sgn_q, sgn_d;
    logic             dz_q, dz_d;
    logic [OUT_W-1:0] out_quot_q, out_quot_d;
    logic [OUT_W-1:0] out_rem_q, out_rem_d;
    logic             out_dz_q, out_dz_d;

    logic             in_neg_a, in_neg_b;
    logic [W-1:0]     in_mag_a, in_mag_b;
    logic [W-1:0]     step_rem;
    logic             step_qbit;

    logic [W-1:0]     fin_quo_mag, fin_rem_mag, fin_dividend;
    logic             fin_neg_q, fin_neg_r, fin_sgn, fin_dz;
    logic [W-1:0]     quot_w, rem_w;
    logic [OUT_W-1:0] quot_ext, rem_ext;

`ifdef SIGNED_DIVMOD_FASTPATH_EN
    logic             fast_hit;
    assign fast_hit = (in_divisor == '0) || (in_dividend == '0);
`endif

    // The single shared iteration, fed from the working registers every CALC cycle
    divmod_step #(.W(W)) u_step (
        .rem_in       (rem_q),
        .dividend_bit (work_q[W-1]),
        .divisor_mag  (dvs_q),
        .rem_out      (step_rem),
        .quot_bit     (step_qbit)
    );

    // Operand signs and magnitudes as presented at the input
    always_comb begin
        in_neg_a = in_signed & in_dividend[W-1];
        in_neg_b = in_signed & in_divisor[W-1];
        in_mag_a = in_neg_a ? -in_dividend : in_dividend;
        in_mag_b = in_neg_b ? -in_divisor : in_divisor;
    end

    // Final result: sign fix-up, zero-divisor override, then extension to OUT_W
    always_comb begin
        fin_quo_mag  = {work_q[W-2:0], step_qbit};
        fin_rem_mag  = step_rem;
        fin_neg_q    = neg_q_q;
        fin_neg_r    = neg_r_q;
        fin_sgn      = sgn_q;
        fin_dz       = dz_q;
        fin_dividend = dividend_q;
`ifdef SIGNED_DIVMOD_FASTPATH_EN
        if (state_q == IDLE) begin
            fin_quo_mag  = '0;
            fin_rem_mag  = '0;
            fin_neg_q    = 1'b0;
            fin_neg_r    = 1'b0;
            fin_sgn      = in_signed;
            fin_dz       = (in_divisor == '0);
            fin_dividend = in_dividend;
        end
`endif
        quot_w   = fin_dz ? ALL_ONES[W-1:0] : (fin_neg_q ? -fin_quo_mag : fin_quo_mag);
        rem_w    = fin_dz ? fin_dividend : (fin_neg_r ? -fin_rem_mag : fin_rem_mag);
        quot_ext = OUT_W'(ext_to_out(MAX_W'(quot_w), W, fin_sgn));
        rem_ext  = OUT_W'(ext_to_out(MAX_W'(rem_w), W, fin_sgn));
    end

    // Next-state logic: accept, iterate W times, then hold until consumed
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef SIGNED_DIVMOD_FASTPATH_EN
                    state_d = fast_hit ? DONE : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: operand capture, per-cycle iteration and result capture
    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        work_d     = work_q;
        dvs_d      = dvs_q;
        dividend_d = dividend_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        sgn_d      = sgn_q;
        dz_d       = dz_q;
        out_quot_d = out_quot_q;
        out_rem_d  = out_rem_q;
        out_dz_d   = out_dz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cnt_d      = CNT_W'(W);
                    rem_d      = '0;
                    work_d     = in_mag_a;
                    dvs_d      = in_mag_b;
                    dividend_d = in_dividend;
                    neg_q_d    = in_neg_a ^ in_neg_b;
                    neg_r_d    = in_neg_a;
                    sgn_d      = in_signed;
                    dz_d       = (in_divisor == '0);
`ifdef SIGNED_DIVMOD_FASTPATH_EN
                    if (fast_hit) begin
                        cnt_d      = '0;
                        out_quot_d = quot_ext;
                        out_rem_d  = rem_ext;
                        out_dz_d   = fin_dz;
                    end
`endif
                end
            end
            CALC: begin
                cnt_d  = cnt_q - CNT_W'(1);
                rem_d  = step_rem;
                work_d = {work_q[W-2:0], step_qbit};
                if (cnt_q == CNT_W'(1)) begin
                    out_quot_d = quot_ext;
                    out_rem_d  = rem_ext;
                    out_dz_d   = fin_dz;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            work_q     <= '0;
            dvs_q      <= '0;
            dividend_q <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            sgn_q      <= 1'b0;
            dz_q       <= 1'b0;
            out_quot_q <= '0;
            out_rem_q  <= '0;
            out_dz_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            work_q     <= work_d;
            dvs_q      <= dvs_d;
            dividend_q <= dividend_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            sgn_q      <= sgn_d;
            dz_q       <= dz_d;
            out_quot_q <= out_quot_d;
            out_rem_q  <= out_rem_d;
            out_dz_q   <= out_dz_d;
        end
    end

    // Handshake outputs decoded from state; results come straight from registers
    always_comb begin
        in_ready     = (state_q == IDLE);
        out_valid    = (state_q == DONE);
        out_quot     = out_quot_q;
        out_rem      = out_rem_q;
        out_div_zero = out_dz_q;
    end

endmodule

// File: tb/tb_signed_divmod_seq.sv
// Self-checking bench for signed_divmod_seq (W=8, OUT_W=12): directed vectors
// with hand-derived results, back-pressure, asynchronous reset mid-iteration,
// and random operands checked against integer '/' and '%' arithmetic.
// Honours SIGNED_DIVMOD_FASTPATH_EN when the bench is built with it.
module tb_signed_divmod_seq;

    localparam int W     = 8;
    localparam int OUT_W = 12;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_dividend;
    logic [W-1:0]     in_divisor;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_quot;
    logic [OUT_W-1:0] out_rem;
    logic             out_div_zero;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [11:0] q;
        logic [11:0] r;
        logic        dz;
    } vec_t;

    vec_t dirs[$];

    signed_divmod_seq #(.W(W), .OUT_W(OUT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .in_signed    (in_signed),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quot     (out_quot),
        .out_rem      (out_rem),
        .out_div_zero (out_div_zero)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence itself ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of test, required end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    // Language-level reference: truncating division, remainder follows dividend
    function automatic void ref_model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                      output logic [11:0] q, output logic [11:0] r,
                                      output logic dz);
        int ia, ib, iq, ir;
        logic [7:0] q8, r8;
        if (s) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'({24'h0, a});
            ib = int'({24'h0, b});
        end
        dz = (b == 8'h00);
        if (dz) begin
            q8 = 8'hFF;
            r8 = a;
        end else begin
            iq = ia / ib;
            ir = ia % ib;
            q8 = iq[7:0];
            r8 = ir[7:0];
        end
        if (s) begin
            q = {{4{q8[7]}}, q8};
            r = {{4{r8[7]}}, r8};
        end else begin
            q = {4'h0, q8};
            r = {4'h0, r8};
        end
    endfunction

    // Cycles from the accepting edge to out_valid
    function automatic int exp_latency(input logic [7:0] a, input logic [7:0] b);
`ifdef SIGNED_DIVMOD_FASTPATH_EN
        return (a == 8'h00 || b == 8'h00) ? 1 : W + 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic check_output(input string tag, input string field,
                                input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s.%s: got %0h, required %0h", tag, field, obs, exp);
        end
    endtask

    // Present one operand pair, wait for the accept edge, then count cycles to out_valid
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic s,
                                  output int lat);
        int waited;
        logic seen;
        @(negedge clk);
        waited = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        in_dividend = a;
        in_divisor  = b;
        in_signed   = s;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_dividend = 8'($urandom);
        in_divisor  = 8'($urandom);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 50) begin
            @(negedge clk);
            lat++;
            seen = (out_valid === 1'b1);
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                                 input logic s, input logic [11:0] eq, input logic [11:0] er,
                                 input logic edz);
        int lat;
        apply_stimulus(a, b, s, lat);
        check_output(tag, "latency", lat, exp_latency(a, b));
        check_output(tag, "quot", out_quot, eq);
        check_output(tag, "rem", out_rem, er);
        check_output(tag, "div_zero", out_div_zero, edz);
        consume();
    endtask

    initial begin
        logic [7:0]  ra, rb;
        logic        rs, rdz;
        logic [11:0] rq, rr;
        int          lat;

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_signed   = 1'b0;
        out_ready   = 1'b0;

        // Reset state
        #2;
        check_output("reset", "in_ready", in_ready, 1);
        check_output("reset", "out_valid", out_valid, 0);
        check_output("reset", "quot", out_quot, 0);
        check_output("reset", "rem", out_rem, 0);
        check_output("reset", "div_zero", out_div_zero, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-derived expectations
        dirs.push_back('{8'h00, 8'h02, 1'b1, 12'h000, 12'h000, 1'b0});
        dirs.push_back('{8'hF9, 8'h02, 1'b1, 12'hFFD, 12'hFFF, 1'b0});
        dirs.push_back('{8'h07, 8'hFE, 1'b1, 12'hFFD, 12'h001, 1'b0});
        dirs.push_back('{8'hF9, 8'h02, 1'b0, 12'h07C, 12'h001, 1'b0});
        dirs.push_back('{8'h80, 8'hFF, 1'b1, 12'hF80, 12'h000, 1'b0});
        dirs.push_back('{8'h05, 8'h00, 1'b1, 12'hFFF, 12'h005, 1'b1});
        dirs.push_back('{8'h05, 8'h00, 1'b0, 12'h0FF, 12'h005, 1'b1});
        dirs.push_back('{8'h00, 8'h00, 1'b1, 12'hFFF, 12'h000, 1'b1});
        dirs.push_back('{8'hFF, 8'hFF, 1'b0, 12'h001, 12'h000, 1'b0});
        dirs.push_back('{8'h81, 8'h7F, 1'b1, 12'hFFF, 12'h000, 1'b0});
        dirs.push_back('{8'hFB, 8'h00, 1'b1, 12'hFFF, 12'hFFB, 1'b1});
        dirs.push_back('{8'h64, 8'h07, 1'b0, 12'h00E, 12'h002, 1'b0});
        foreach (dirs[i]) begin
            run_and_check($sformatf("dir%0d", i), dirs[i].a, dirs[i].b, dirs[i].s,
                          dirs[i].q, dirs[i].r, dirs[i].dz);
        end

        // Back-pressure: results held, no acceptance while a result waits
        apply_stimulus(8'hF9, 8'h02, 1'b1, lat);
        check_output("bp", "latency", lat, W + 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            in_dividend = 8'h11;
            in_divisor  = 8'h03;
            in_signed   = 1'b0;
            #1;
            check_output("bp", "out_valid", out_valid, 1);
            check_output("bp", "in_ready", in_ready, 0);
            check_output("bp", "quot", out_quot, 12'hFFD);
            check_output("bp", "rem", out_rem, 12'hFFF);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume();
        @(negedge clk);
        check_output("bp_after", "in_ready", in_ready, 1);
        check_output("bp_after", "out_valid", out_valid, 0);
        check_output("bp_after", "quot_held", out_quot, 12'hFFD);
        check_output("bp_after", "rem_held", out_rem, 12'hFFF);
        repeat (3) begin
            @(negedge clk);
            check_output("bp_ignored", "out_valid", out_valid, 0);
        end

        // Asynchronous reset in the middle of the iterations
        @(negedge clk);
        in_dividend = 8'h64;
        in_divisor  = 8'h07;
        in_signed   = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_output("rst_calc", "in_ready", in_ready, 1);
        check_output("rst_calc", "out_valid", out_valid, 0);
        check_output("rst_calc", "quot", out_quot, 0);
        check_output("rst_calc", "rem", out_rem, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 3) begin
            @(negedge clk);
            check_output("rst_calc_quiet", "out_valid", out_valid, 0);
        end
        run_and_check("post_rst", 8'h64, 8'h07, 1'b0, 12'h00E, 12'h002, 1'b0);

        // Random operands against the arithmetic reference
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rs = 1'($urandom);
            if ($urandom_range(0, 9) == 0) ra = 8'h00;
            ref_model(ra, rb, rs, rq, rr, rdz);
            run_and_check($sformatf("rnd%0d", n), ra, rb, rs, rq, rr, rdz);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
